// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-side and execute-side handshakes of the instruction-fetch
// sequencer. master = sequencer, slave = memory / execute stage.
interface pc_seq_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req_valid, imem_req_addr, imem_rsp_ready,
           inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_rsp_ready,
           inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           inst_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: instruction-fetch sequencer. Owns the PC, cycles REQ -> WAIT -> EXEC,
// applies +4 or redirected next-PC, halts on ebreak or misaligned redirect,
// and counts retired instructions.
// Optional feature: define PC_SEQ_TIMEOUT_EN to halt with a fault when a
// fetch response does not arrive within MAX_WAIT cycles.
module pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  pc_seq_if.master    bus,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] inst_q;
  // Registered per-state output flags, so no input reaches a valid/ready.
  logic        req_valid_q;
  logic        rsp_ready_q;
  logic        inst_valid_q;
  logic        halted_q;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int WCW = (MAX_WAIT > 15) ? $clog2(MAX_WAIT + 1) : 4;
  logic [WCW-1:0] wait_cnt;
`endif

  // Fetch/execute FSM with PC, instruction latch, retire counter and fault.
  // NOTE: every register here is assigned with <= so all updates in this
  // block see pre-edge values and simulate the same as the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      inst_q       <= '0;
      retired      <= '0;
      fault        <= 1'b0;
      req_valid_q  <= 1'b1;
      rsp_ready_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
`ifdef PC_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (bus.imem_req_ready) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b1;
`ifdef PC_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            inst_q       <= bus.imem_rsp_data;
            state        <= EXEC;
            rsp_ready_q  <= 1'b0;
            inst_valid_q <= 1'b1;
          end
`ifdef PC_SEQ_TIMEOUT_EN
          // A response in the limit cycle is taken by the branch above.
          else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
            fault       <= 1'b1;
            state       <= HALT;
            rsp_ready_q <= 1'b0;
            halted_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        EXEC: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            if (bus.halt) begin
              state    <= HALT;
              halted_q <= 1'b1;
              retired  <= retired + 32'd1;
            end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
              fault    <= 1'b1;
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc          <= bus.redirect_valid ? bus.redirect_pc : pc + 32'd4;
              retired     <= retired + 32'd1;
              state       <= REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        HALT: ;
        default: begin
          state        <= HALT;
          req_valid_q  <= 1'b0;
          rsp_ready_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          halted_q     <= 1'b1;
        end
      endcase
    end
  end

  // Output decode: flags are forced low while reset is held.
  assign bus.imem_req_valid = req_valid_q & ~rst;
  assign bus.imem_req_addr  = pc;
  assign bus.imem_rsp_ready = rsp_ready_q & ~rst;
  assign bus.inst_valid     = inst_valid_q & ~rst;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = pc;
  assign halted             = halted_q & ~rst;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scenario tasks drive pc_seq through reset, sequential fetch,
// redirects, stalls, halt, misaligned redirect and reset during WAIT. Fetched
// words go to a scoreboard queue and are compared when execute sees them.
module tb_pc_seq;

  localparam logic [31:0] RESET_PC = 32'h80000000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  pc_seq_if bus ();

  pc_seq #(.RESET_PC(RESET_PC), .MAX_WAIT(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .pc      (pc),
    .halted  (halted),
    .fault   (fault),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_fault;
  logic        m_halted;
  int          last_req_cyc;

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
  endtask

  // Hold rst for one edge, release at a negedge; the DUT is then in REQ.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_pc      = RESET_PC;
    m_retired = '0;
    m_fault   = 1'b0;
    m_halted  = 1'b0;
    sb.delete();
  endtask

  // One instruction: request (optionally stalled), response (optionally
  // delayed), EXEC (optionally held), then retire with the given controls.
  task automatic fetch_one(input int req_delay, input int rsp_delay, input int exec_delay,
                           input logic redir, input logic [31:0] rpc, input logic hlt);
    int          n;
    exp_t        e;
    logic [31:0] d;
    n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req_valid !== 1'b1) begin
      $display("FAIL req_timeout: imem_req_valid=%b required 1 within 20 cycles", bus.imem_req_valid);
      errors++;
      return;
    end
    last_req_cyc = cyc;
    checks++;
    if (bus.imem_req_addr !== m_pc) begin
      $display("FAIL req_addr: got %h required %h", bus.imem_req_addr, m_pc);
      errors++;
    end
    for (int i = 0; i < req_delay; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== m_pc) begin
        $display("FAIL req_hold: valid=%b addr=%h required 1 %h", bus.imem_req_valid, bus.imem_req_addr, m_pc);
        errors++;
      end
    end
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    checks++;
    if (bus.imem_rsp_ready !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      $display("FAIL wait_entry: rsp_ready=%b req_valid=%b required 1 0", bus.imem_rsp_ready, bus.imem_req_valid);
      errors++;
    end
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_rsp_ready !== 1'b1 || bus.inst_valid !== 1'b0) begin
        $display("FAIL wait_hold: rsp_ready=%b inst_valid=%b required 1 0", bus.imem_rsp_ready, bus.inst_valid);
        errors++;
      end
    end
    d = $urandom();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    sb.push_back('{pc: m_pc, data: d});
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = ~d;
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      $display("FAIL exec_entry: inst_valid=%b required 1", bus.inst_valid);
      errors++;
    end
    e = sb.pop_front();
    checks++;
    if (bus.inst !== e.data || bus.inst_pc !== e.pc) begin
      $display("FAIL inst_word: inst=%h pc=%h required %h %h", bus.inst, bus.inst_pc, e.data, e.pc);
      errors++;
    end
    for (int i = 0; i < exec_delay; i++) begin
      bus.halt           = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h00000003;
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== e.data || pc !== m_pc || halted !== 1'b0) begin
        $display("FAIL exec_hold: inst_valid=%b inst=%h pc=%h halted=%b required 1 %h %h 0",
                 bus.inst_valid, bus.inst, pc, halted, e.data, m_pc);
        errors++;
      end
    end
    bus.halt           = hlt;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = 1'b1;
    @(negedge clk);
    bus.inst_ready     = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    if (hlt) begin
      m_retired = m_retired + 32'd1;
      m_halted  = 1'b1;
    end else if (redir && rpc[1:0] != 2'b00) begin
      m_fault  = 1'b1;
      m_halted = 1'b1;
    end else begin
      m_pc      = redir ? rpc : m_pc + 32'd4;
      m_retired = m_retired + 32'd1;
    end
    checks++;
    if (pc !== m_pc || retired !== m_retired || fault !== m_fault || halted !== m_halted) begin
      $display("FAIL retire: pc=%h retired=%0d fault=%b halted=%b required %h %0d %b %b",
               pc, retired, fault, halted, m_pc, m_retired, m_fault, m_halted);
      errors++;
    end
    checks++;
    if (bus.imem_req_valid !== !m_halted || bus.inst_valid !== 1'b0) begin
      $display("FAIL post_retire: req_valid=%b inst_valid=%b required %b 0",
               bus.imem_req_valid, bus.inst_valid, !m_halted);
      errors++;
    end
  endtask

  // Several cycles after halting: no request or ready may reappear.
  task automatic check_stays_halted(input string name);
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.inst_ready     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0 ||
          bus.inst_valid !== 1'b0 || pc !== m_pc || retired !== m_retired || fault !== m_fault) begin
        $display("FAIL %s: halted=%b req_v=%b rsp_r=%b inst_v=%b pc=%h ret=%0d fault=%b required 1 0 0 0 %h %0d %b",
                 name, halted, bus.imem_req_valid, bus.imem_rsp_ready, bus.inst_valid,
                 pc, retired, fault, m_pc, m_retired, m_fault);
        errors++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0 ||
        bus.inst_valid !== 1'b0 || halted !== 1'b0) begin
      $display("FAIL reset_forced: req_v=%b rsp_r=%b inst_v=%b halted=%b required 0 0 0 0",
               bus.imem_req_valid, bus.imem_rsp_ready, bus.inst_valid, halted);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (pc !== RESET_PC || retired !== 32'd0 || fault !== 1'b0 || bus.inst !== 32'd0 ||
        bus.imem_req_valid !== 1'b0) begin
      $display("FAIL reset_values: pc=%h retired=%0d fault=%b inst=%h req_v=%b required %h 0 0 0 0",
               pc, retired, fault, bus.inst, bus.imem_req_valid, RESET_PC);
      errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      $display("FAIL first_req: req_v=%b addr=%h required 1 %h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
      errors++;
    end
    m_pc      = RESET_PC;
    m_retired = '0;
    m_fault   = 1'b0;
    m_halted  = 1'b0;
  endtask

  task automatic test_sequential();
    int t0;
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    t0 = last_req_cyc;
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    checks++;
    if (last_req_cyc - t0 !== 3) begin
      $display("FAIL seq_spacing1: got %0d cycles required 3", last_req_cyc - t0);
      errors++;
    end
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    checks++;
    if (last_req_cyc - t0 !== 6) begin
      $display("FAIL seq_spacing2: got %0d cycles required 6", last_req_cyc - t0);
      errors++;
    end
    checks++;
    if (retired !== 32'd3 || pc !== 32'h8000000C) begin
      $display("FAIL seq_retired: retired=%0d pc=%h required 3 8000000c", retired, pc);
      errors++;
    end
  endtask

  task automatic test_redirect();
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    checks++;
    if (pc !== 32'h80000010) begin
      $display("FAIL redir_setup: pc=%h required 80000010", pc);
      errors++;
    end
    fetch_one(0, 0, 0, 1'b1, 32'h80000100, 1'b0);
    checks++;
    if (bus.imem_req_addr !== 32'h80000100 || retired !== 32'd5) begin
      $display("FAIL redir_target: addr=%h retired=%0d required 80000100 5", bus.imem_req_addr, retired);
      errors++;
    end
  endtask

  task automatic test_stall();
    fetch_one(5, 4, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_exec_hold();
    fetch_one(0, 1, 2, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    fetch_one(0, 0, 0, 1'b1, 32'hFFFFFFFC, 1'b0);
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    checks++;
    if (pc !== 32'h00000000) begin
      $display("FAIL pc_wrap: pc=%h required 00000000", pc);
      errors++;
    end
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_halt();
    do_reset();
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    fetch_one(0, 0, 0, 1'b1, 32'h80000200, 1'b1);
    checks++;
    if (pc !== 32'h80000008 || halted !== 1'b1 || fault !== 1'b0 || retired !== 32'd3) begin
      $display("FAIL halt_state: pc=%h halted=%b fault=%b retired=%0d required 80000008 1 0 3",
               pc, halted, fault, retired);
      errors++;
    end
    check_stays_halted("halt_sticky");
  endtask

  task automatic test_misaligned();
    do_reset();
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    fetch_one(0, 0, 0, 1'b1, 32'h80000102, 1'b0);
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || pc !== 32'h80000004 || retired !== 32'd1) begin
      $display("FAIL misaligned: fault=%b halted=%b pc=%h retired=%0d required 1 1 80000004 1",
               fault, halted, pc, retired);
      errors++;
    end
    check_stays_halted("fault_sticky");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    checks++;
    if (bus.imem_rsp_ready !== 1'b1) begin
      $display("FAIL rst_wait_setup: rsp_ready=%b required 1", bus.imem_rsp_ready);
      errors++;
    end
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0;
    m_pc      = RESET_PC;
    m_retired = '0;
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC || retired !== 32'd0 ||
        bus.inst_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0) begin
      $display("FAIL rst_wait: req_v=%b addr=%h retired=%0d inst_v=%b rsp_r=%b required 1 %h 0 0 0",
               bus.imem_req_valid, bus.imem_req_addr, retired, bus.inst_valid, bus.imem_rsp_ready, RESET_PC);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0 || bus.inst !== 32'd0) begin
      $display("FAIL late_rsp_ignored: req_v=%b inst_v=%b inst=%h required 1 0 00000000",
               bus.imem_req_valid, bus.inst_valid, bus.inst);
      errors++;
    end
    bus.imem_rsp_valid = 1'b0;
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t0;
    fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
    t0 = last_req_cyc;
    for (int i = 1; i <= 6; i++) begin
      fetch_one(0, 0, 0, 1'b0, '0, 1'b0);
      checks++;
      if (last_req_cyc - t0 !== 3 * i) begin
        $display("FAIL b2b_spacing: got %0d cycles required %0d", last_req_cyc - t0, 3 * i);
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_exec_hold();
    test_wrap();
    test_back_to_back();
    test_halt();
    test_misaligned();
    test_reset_in_wait();
    checks++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
